// File: rtl/spi_rd_arbiter.sv
// Shares one spi_master flash-read port between requesters A and B. Each read is
// serialised, granted round-robin, and abandoned after TMO_CYC cycles with no data.
module spi_rd_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 32,
    parameter int TMO_CYC = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req_valid,
    input  logic [AW-1:0] a_req_addr,
    output logic          a_req_ready,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_rsp_data,
    output logic          a_rsp_err,
    input  logic          a_rsp_ack,
    input  logic          b_req_valid,
    input  logic [AW-1:0] b_req_addr,
    output logic          b_req_ready,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_rsp_data,
    output logic          b_rsp_err,
    input  logic          b_rsp_ack,
    input  logic          m_addr_buffer_free,
    output logic          m_addr_en,
    output logic [AW-1:0] m_addr_data,
    input  logic          m_rd_data_available,
    output logic          m_rd_ack,
    input  logic [DW-1:0] m_rd_data,
    output logic          busy,
    output logic          owner
);
    localparam int TW = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

    state_t        state, state_d;
    logic          last_served, last_served_d;
    logic [TW-1:0] timer, timer_d;
    logic          owner_d, busy_d;
    logic [AW-1:0] m_addr_data_d;
    logic          a_req_ready_d, b_req_ready_d, m_addr_en_d, m_rd_ack_d;
    logic          a_rsp_valid_d, b_rsp_valid_d, a_rsp_err_d, b_rsp_err_d;
    logic [DW-1:0] a_rsp_data_d, b_rsp_data_d;
    logic          word_take;

    // A word still visible while our ack is on the wire is the one being consumed.
    assign word_take = m_rd_data_available && !m_rd_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last_served <= 1'b1;
            timer       <= '0;
            owner       <= 1'b0;
            busy        <= 1'b0;
            m_addr_data <= '0;
            a_req_ready <= 1'b0;
            b_req_ready <= 1'b0;
            m_addr_en   <= 1'b0;
            m_rd_ack    <= 1'b0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            a_rsp_err   <= 1'b0;
            b_rsp_err   <= 1'b0;
            a_rsp_data  <= '0;
            b_rsp_data  <= '0;
        end else begin
            state       <= state_d;
            last_served <= last_served_d;
            timer       <= timer_d;
            owner       <= owner_d;
            busy        <= busy_d;
            m_addr_data <= m_addr_data_d;
            a_req_ready <= a_req_ready_d;
            b_req_ready <= b_req_ready_d;
            m_addr_en   <= m_addr_en_d;
            m_rd_ack    <= m_rd_ack_d;
            a_rsp_valid <= a_rsp_valid_d;
            b_rsp_valid <= b_rsp_valid_d;
            a_rsp_err   <= a_rsp_err_d;
            b_rsp_err   <= b_rsp_err_d;
            a_rsp_data  <= a_rsp_data_d;
            b_rsp_data  <= b_rsp_data_d;
        end
    end

    always_comb begin
        state_d       = state;
        last_served_d = last_served;
        timer_d       = timer;
        owner_d       = owner;
        m_addr_data_d = m_addr_data;
        a_req_ready_d = 1'b0;
        b_req_ready_d = 1'b0;
        m_addr_en_d   = 1'b0;
        m_rd_ack_d    = 1'b0;
        a_rsp_valid_d = a_rsp_valid;
        b_rsp_valid_d = b_rsp_valid;
        a_rsp_err_d   = a_rsp_err;
        b_rsp_err_d   = b_rsp_err;
        a_rsp_data_d  = a_rsp_data;
        b_rsp_data_d  = b_rsp_data;

        case (state)
            S_IDLE: begin
                // On a tie, the requester not served last wins.
                if (a_req_valid && (!b_req_valid || last_served)) begin
                    owner_d       = 1'b0;
                    m_addr_data_d = a_req_addr;
                    a_req_ready_d = 1'b1;
                    state_d       = S_ISSUE;
                end else if (b_req_valid) begin
                    owner_d       = 1'b1;
                    m_addr_data_d = b_req_addr;
                    b_req_ready_d = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_addr_buffer_free) begin
                    m_addr_en_d = 1'b1;
                    timer_d     = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (word_take) begin
                    m_rd_ack_d = 1'b1;
                    state_d    = S_DELIVER;
                    if (owner) begin
                        b_rsp_valid_d = 1'b1;
                        b_rsp_data_d  = m_rd_data;
                        b_rsp_err_d   = 1'b0;
                    end else begin
                        a_rsp_valid_d = 1'b1;
                        a_rsp_data_d  = m_rd_data;
                        a_rsp_err_d   = 1'b0;
                    end
                end else if (timer == TW'(TMO_CYC - 1)) begin
                    state_d = S_DELIVER;
                    if (owner) begin
                        b_rsp_valid_d = 1'b1;
                        b_rsp_data_d  = '0;
                        b_rsp_err_d   = 1'b1;
                    end else begin
                        a_rsp_valid_d = 1'b1;
                        a_rsp_data_d  = '0;
                        a_rsp_err_d   = 1'b1;
                    end
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            S_DELIVER: begin
                if (owner ? (b_rsp_valid && b_rsp_ack) : (a_rsp_valid && a_rsp_ack)) begin
                    a_rsp_valid_d = 1'b0;
                    b_rsp_valid_d = 1'b0;
                    last_served_d = owner;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Late words arriving after a timeout are drained and dropped.
        if (state != S_WAIT && word_take) begin
            m_rd_ack_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end
endmodule
